// File: rtl/apb_ctrl_pkg.sv
// Shared types and defaults for the APB master arbiter.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DERR
    } apb_state_e;

    localparam int DEF_NREQ    = 2;
    localparam int DEF_NSLV    = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_SEL_LSB = 8;
    localparam int DEF_TIMEOUT = 16;

    function automatic int slv_idx_w(input int nslv);
        return $clog2(nslv);
    endfunction

    localparam int SLV_IDX_W = slv_idx_w(DEF_NSLV);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter  int NREQ  = 2,
    localparam int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    int j;

    // Scan from the farthest offset down so the nearest request is written last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = PTR_W'(j);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master sequencing NREQ requesters onto NSLV slaves.
// Optional ACCESS timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NREQ           = DEF_NREQ,
    parameter int NSLV           = DEF_NSLV,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SEL_LSB        = DEF_SEL_LSB,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                   P_clk,
    input  logic                   P_rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        req_accept,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_W-1:0]      P_addr,
    output logic [NSLV-1:0]        P_selx,
    output logic                   P_enable,
    output logic                   P_write,
    output logic [DATA_W-1:0]      P_wdata,
    input  logic                   P_ready,
    input  logic                   P_slverr,
    input  logic [DATA_W-1:0]      P_rdata
);

    localparam int PTR_W   = $clog2(NREQ);
    localparam int IDX_W   = slv_idx_w(NSLV);
    localparam int TOP_LSB = SEL_LSB + IDX_W;

    if (NREQ < 2 || NSLV < 2 || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("apb_master_arbiter: unsupported parameter set");
    end

    apb_state_e        state_q;
    logic [PTR_W-1:0]  rr_ptr_q, owner_q, ptr_nxt, arb_ptr_d, arb_idx;
    logic [NREQ-1:0]   arb_gnt, req_accept_q, rsp_valid_q;
    logic              arb_any, launch, dec_ok;
    logic [ADDR_W-1:0] win_addr, P_addr_q;
    logic [DATA_W-1:0] win_wdata, P_wdata_q, rsp_rdata_q;
    logic [NSLV-1:0]   win_oh, P_selx_q;
    logic              P_enable_q, P_write_q, rsp_err_q;
`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]  tmo_q;
`endif

    // On a completing ACCESS the pointer is about to move past the owner,
    // so a back-to-back pick must already use the advanced value.
    assign ptr_nxt   = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign arb_ptr_d = (state_q == ACCESS) ? ptr_nxt : rr_ptr_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (arb_ptr_d),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign win_addr  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
    assign win_wdata = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
    assign dec_ok    = (win_addr >> TOP_LSB) == '0;
    assign win_oh    = NSLV'(1) << win_addr[SEL_LSB +: IDX_W];
    assign launch    = arb_any && (state_q == IDLE || (state_q == ACCESS && P_ready));

    always_ff @(posedge P_clk) begin
        if (!P_rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            req_accept_q <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            P_addr_q     <= '0;
            P_selx_q     <= '0;
            P_enable_q   <= 1'b0;
            P_write_q    <= 1'b0;
            P_wdata_q    <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            req_accept_q <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            case (state_q)
                IDLE: ;
                SETUP: begin
                    P_enable_q <= 1'b1;
                    state_q    <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    tmo_q      <= '0;
`endif
                end
                ACCESS: begin
                    if (P_ready) begin
                        rsp_valid_q <= NREQ'(1) << owner_q;
                        rsp_err_q   <= P_slverr;
                        rsp_rdata_q <= P_write_q ? '0 : P_rdata;
                        rr_ptr_q    <= ptr_nxt;
                        P_selx_q    <= '0;
                        P_enable_q  <= 1'b0;
                        state_q     <= IDLE;
`ifdef APB_TIMEOUT_EN
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid_q <= NREQ'(1) << owner_q;
                        rsp_err_q   <= 1'b1;
                        rr_ptr_q    <= ptr_nxt;
                        P_selx_q    <= '0;
                        P_enable_q  <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
`endif
                    end
                end
                DERR: begin
                    rsp_valid_q <= NREQ'(1) << owner_q;
                    rsp_err_q   <= 1'b1;
                    rr_ptr_q    <= ptr_nxt;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // A new grant overrides the return-to-IDLE assignments above.
            if (launch) begin
                req_accept_q <= arb_gnt;
                owner_q      <= arb_idx;
                P_addr_q     <= win_addr;
                P_write_q    <= req_write[arb_idx];
                P_wdata_q    <= win_wdata;
                P_enable_q   <= 1'b0;
                P_selx_q     <= dec_ok ? win_oh : '0;
                state_q      <= dec_ok ? SETUP : DERR;
            end
        end
    end

    assign req_accept = req_accept_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign P_addr     = P_addr_q;
    assign P_selx     = P_selx_q;
    assign P_enable   = P_enable_q;
    assign P_write    = P_write_q;
    assign P_wdata    = P_wdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed plus randomized bench for apb_master_arbiter against a transaction-level model.
module tb_apb_master_arbiter;

    localparam int NREQ = 2;
    localparam int NSLV = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic                 P_clk = 1'b0;
    logic                 P_rst_n;
    logic [NREQ-1:0]      req_valid, req_write, req_accept, rsp_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [DW-1:0]        rsp_rdata, P_wdata, P_rdata;
    logic                 rsp_err, P_enable, P_write, P_ready, P_slverr;
    logic [AW-1:0]        P_addr;
    logic [NSLV-1:0]      P_selx;

    int              n_chk = 0;
    int              n_fail = 0;
    int              m_ptr = 0;
    logic [NREQ-1:0] m_mask;
    bit              b2b;

    always #5 P_clk = ~P_clk;

    apb_master_arbiter dut (
        .P_clk(P_clk), .P_rst_n(P_rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_accept(req_accept), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .P_addr(P_addr), .P_selx(P_selx), .P_enable(P_enable), .P_write(P_write), .P_wdata(P_wdata),
        .P_ready(P_ready), .P_slverr(P_slverr), .P_rdata(P_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    task automatic tick();
        @(posedge P_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid[i]          = 1'b1;
        req_write[i]          = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic start();
        m_mask = req_valid;
        tick();
    endtask

    // Entry: sample point right after the edge that accepted a request.
    task automatic serve(input int waits, input logic serr, input logic [31:0] rd,
                         input bit drop, input bit clr);
        int              w;
        logic [31:0]     a, d;
        logic            wr, derr;
        logic [NSLV-1:0] oh;
        w    = pick(m_mask, m_ptr);
        a    = req_addr[w*AW +: AW];
        d    = req_wdata[w*DW +: DW];
        wr   = req_write[w];
        derr = a >= 32'h400;
        oh   = NSLV'(1) << ((a >> 8) % NSLV);
        chk("accept", req_accept, NREQ'(1) << w);
        chk("setup_selx", P_selx, derr ? '0 : oh);
        chk("setup_enable", P_enable, 0);
        if (!derr) begin
            chk("setup_addr", P_addr, a);
            chk("setup_write", P_write, wr);
            if (wr) chk("setup_wdata", P_wdata, d);
        end
        if (drop) req_valid[w] = 1'b0;
        m_ptr = (w + 1) % NREQ;
        if (derr) begin
            tick();
            chk("derr_rsp", rsp_valid, NREQ'(1) << w);
            chk("derr_err", rsp_err, 1);
            chk("derr_rdata", rsp_rdata, 0);
            chk("derr_selx", P_selx, 0);
            b2b = 1'b0;
        end else begin
            for (int k = 0; k <= waits; k++) begin
                tick();
                chk("acc_enable", P_enable, 1);
                chk("acc_selx", P_selx, oh);
                chk("acc_addr", P_addr, a);
                chk("acc_norsp", rsp_valid, 0);
                P_ready  = (k == waits);
                P_slverr = (k == waits) ? serr : 1'($urandom);
                P_rdata  = (k == waits) ? rd : $urandom;
            end
            if (clr) req_valid = '0;
            m_mask = req_valid;
            b2b    = (m_mask != 0);
            tick();
            P_ready  = 1'b0;
            P_slverr = 1'b0;
            chk("rsp_valid", rsp_valid, NREQ'(1) << w);
            chk("rsp_err", rsp_err, serr);
            chk("rsp_rdata", rsp_rdata, wr ? 32'h0 : rd);
            if (!b2b) begin
                chk("idle_selx", P_selx, 0);
                chk("idle_enable", P_enable, 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        P_rst_n   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        P_ready   = 1'b0;
        P_slverr  = 1'b0;
        P_rdata   = '0;
        tick();
        tick();
        chk("rst_selx", P_selx, 0);
        chk("rst_enable", P_enable, 0);
        chk("rst_accept", req_accept, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_addr", P_addr, 0);
        P_rst_n = 1'b1;
        tick();

        // Zero-wait write to slave 1, then 3-wait read from slave 1
        set_req(0, 1'b1, 32'h0000_0104, 32'hA5);
        start();
        chk("wr_selx_0010", P_selx, 4'b0010);
        serve(0, 1'b0, 32'h0, 1'b1, 1'b0);
        set_req(1, 1'b0, 32'h0000_0100, 32'h0);
        start();
        serve(3, 1'b0, 32'h1234, 1'b1, 1'b0);

        // Both requesters held: 4 back-to-back transfers
        set_req(0, 1'b0, 32'h0000_0200, 32'h0);
        set_req(1, 1'b1, 32'h0000_0300, 32'h55);
        start();
        for (int k = 0; k < 4; k++) begin
            chk("b2b_order", req_accept, NREQ'(1) << (k % 2));
            serve(k % 3, 1'b0, 32'hC0DE_0000 + k, 1'b0, k == 3);
        end

        // Decode error, then slave error
        set_req(0, 1'b0, 32'h0001_0000, 32'h0);
        start();
        serve(0, 1'b0, 32'h0, 1'b1, 1'b0);
        set_req(1, 1'b1, 32'h0000_0304, 32'h77);
        start();
        serve(1, 1'b1, 32'h0, 1'b1, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            if (req_valid == '0) begin
                logic [NREQ-1:0] mk;
                mk = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                for (int i = 0; i < NREQ; i++) begin
                    if (mk[i]) begin
                        logic [31:0] ra;
                        ra = ($urandom_range(0, 4) == 0) ? $urandom
                             : (($urandom_range(0, NSLV - 1) << 8) | $urandom_range(0, 255));
                        set_req(i, 1'($urandom), ra, $urandom);
                    end
                end
            end
            start();
            do serve($urandom_range(0, 3), 1'($urandom), $urandom, 1'b1, 1'b0); while (b2b);
        end
        while (req_valid != '0) begin
            start();
            do serve(0, 1'b0, $urandom, 1'b1, 1'b0); while (b2b);
        end

        // Reset during ACCESS with the pointer parked at 1
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        start();
        serve(0, 1'b0, 32'h1111, 1'b1, 1'b0);
        set_req(1, 1'b0, 32'h0000_0200, 32'h0);
        start();
        req_valid[1] = 1'b0;
        tick();
        chk("pre_rst_enable", P_enable, 1);
        P_rst_n = 1'b0;
        tick();
        chk("midrst_selx", P_selx, 0);
        chk("midrst_enable", P_enable, 0);
        chk("midrst_rsp", rsp_valid, 0);
        chk("midrst_addr", P_addr, 0);
        P_rst_n = 1'b1;
        P_ready = 1'b1;
        tick();
        P_ready = 1'b0;
        chk("postrst_norsp", rsp_valid, 0);
        m_ptr = 0;
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        set_req(1, 1'b0, 32'h0000_0200, 32'h0);
        start();
        chk("postrst_winner0", req_accept, 2'b01);
        do serve(0, 1'b0, $urandom, 1'b1, 1'b0); while (b2b);

`ifdef APB_TIMEOUT_EN
        // Slave never ready: abort after 16 ACCESS cycles
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        start();
        chk("tmo_accept", req_accept, 2'b01);
        req_valid[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("tmo_enable", P_enable, 1);
        end
        tick();
        chk("tmo_rsp", rsp_valid, 2'b01);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_rdata", rsp_rdata, 0);
        chk("tmo_selx", P_selx, 0);
        chk("tmo_enable_off", P_enable, 0);
        m_ptr = 1;
        // Ready on the 16th ACCESS cycle completes normally
        set_req(1, 1'b0, 32'h0000_0100, 32'h0);
        start();
        serve(15, 1'b0, 32'h5A5A, 1'b1, 1'b0);
`else
        set_req(1, 1'b0, 32'h0000_0100, 32'h0);
        start();
        serve(20, 1'b0, 32'h5A5A, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
